axi_read_slave_resp: RTL and testbench
======================================

Name: axi_read_slave_resp

Overview:
AXI4 read-channel responder. It is the read-direction counterpart of the write-channel master/slave pair.
- Accepts one AR request at a time.
- Generates per-beat addresses for FIXED, INCR and WRAP bursts.
- Fetches each beat from a fixed-latency (1-cycle) memory port.
- Returns R beats with RID, RRESP and RLAST under RREADY backpressure.
- Sits between the AXI interconnect and a local SRAM/register backing store.

Parameters:
IDW, 12, AR/R ID width
AW, 32, address width
DW, 64, data width in bits (power of 2, 8..1024)

Ports:
- clk  input  1  global clock
- resetn  input  1  asynchronous active-low reset
- s_axi_arid  input  IDW  read ID
- s_axi_araddr  input  AW  burst start address
- s_axi_arlen  input  8  beats minus 1
- s_axi_arsize  input  3  log2 bytes per beat
- s_axi_arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_axi_arvalid  input  1  address valid
- s_axi_arready  output  1  address accepted
- s_axi_rid  output  IDW  response ID
- s_axi_rdata  output  DW  read data
- s_axi_rresp  output  2  00 OKAY, 10 SLVERR
- s_axi_rlast  output  1  final beat of the burst
- s_axi_rvalid  output  1  beat valid
- s_axi_rready  input  1  master accepts beat
- mem_req  output  1  memory read strobe
- mem_addr  output  AW  beat address
- mem_rdata  input  DW  data, valid exactly 1 cycle after mem_req

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; all outputs 0, including arready, rvalid, rlast, rresp, rid, rdata, mem_req and mem_addr. Internal beat counter and address registers are cleared.
- States: IDLE, FETCH, CAPTURE, RESP.
- IDLE:
  - arready=1.
  - On arvalid&arready, latch id, addr, len, size and burst. Beat count = 0.
  - Compute err = (arsize > log2(DW/8)) | (arburst==11) | (arburst==WRAP & arlen not in {1,3,7,15}).
  - If err, go to RESP with rdata=0 and rresp=10. Otherwise go to FETCH.
- FETCH: mem_req=1 and mem_addr = current beat address for this cycle only. Next state CAPTURE.
- CAPTURE: register mem_rdata into rdata; rresp=00; rvalid=1; rlast = (count==len). Next state RESP.
- RESP:
  - Hold rvalid and every R field stable until rready.
  - On rvalid&rready: if rlast, go to IDLE (rvalid=0). Otherwise count+1 and advance the address.
  - Non-error burst: next state FETCH.
  - Error burst: stay in RESP, present the next SLVERR beat on the next cycle, and issue no mem_req. There is one idle cycle between error beats.
- arready is 0 in every state other than IDLE. There is no outstanding-transaction overlap.
- Throughput: non-error beats take 3 cycles each with rready held high. Latency from AR handshake to first rvalid is 2 cycles (FETCH, CAPTURE).
- Address advance, with S = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr_aligned = addr & ~(S-1); next = addr_aligned + S. Width is AW and wraps modulo 2^AW.
  - WRAP: L = (len+1)*S; base = addr & ~(L-1); next = base | ((addr + S) & (L-1)).
- The first beat uses the unaligned start address on mem_addr. Later INCR beats are aligned.
- rlast is asserted only on beat count==len. arlen=0 gives a single beat with rlast=1.
- An arvalid arriving while not in IDLE is ignored (not latched) and must stay pending per AXI rules.
- resetn asserted mid-burst: immediate return to IDLE with outputs cleared. No remaining beats are emitted after release.

Decomposition:
- Package axi_pkg holds:
  - the burst enum: FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - the RRESP constants OKAY=2'b00 and SLVERR=2'b10;
  - the state enum.
- One sub-module, axi_burst_addr_gen: combinational next-address function taking addr, len, size and burst. It is shared with the write-side slave.

Test Plan:
1. INCR, araddr=0x1000, arlen=3, arsize=3, rready=1:
   - mem_addr sequence is 0x1000, 0x1008, 0x1010, 0x1018.
   - 4 beats with rresp=00; rlast only on beat 4; arready returns 1 the cycle after the last handshake.
2. WRAP, araddr=0x1038, arlen=7, arsize=3:
   - mem_addr sequence is 0x1038, 0x1000, 0x1008, …, 0x1030.
3. FIXED, araddr=0x20, arlen=2: mem_addr=0x20 for all 3 beats, and rid echoes arid=0xABC.
4. Backpressure: rready=0 for 5 cycles on beat 2 of INCR arlen=1.
   - rvalid, rdata and rlast stay stable throughout.
   - No mem_req is issued until the handshake completes.
5. Errors:
   - arsize=4 (DW=64), arlen=1: 2 beats with rresp=10, rdata=0, rlast on beat 2, zero mem_req pulses.
   - WRAP with arlen=2 gives the same SLVERR result.
6. Mid-burst reset: resetn=0 during beat 2 of arlen=7.
   - All outputs are 0 asynchronously.
   - After release, arready=1 and no stale rvalid appears.

Source files
------------

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 definitions for the read-channel responder and its burst
// address generator: burst type encodings, RRESP codes and the responder
// state machine encoding.
// ---------------------------------------------------------------------------
package axi_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10
   } burst_e;

   localparam logic [1:0] BURST_RSVD = 2'b11;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      CAPTURE,
      RESP
   } state_e;

   // A WRAP burst is only legal for 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational AXI4 next-beat address function, shared by the read and
// write slaves.
//   addr      : current beat address (may be unaligned on the first beat)
//   len       : burst length minus one
//   size      : log2 of bytes per beat
//   burst     : FIXED / INCR / WRAP (reserved encoding holds the address)
//   next_addr : address of the following beat, modulo 2^AW
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] addr,
   input  logic [7:0]    len,
   input  logic [2:0]    size,
   input  logic [1:0]    burst,
   output logic [AW-1:0] next_addr
);

   logic [AW-1:0] beat_bytes;
   logic [AW-1:0] size_mask;
   logic [AW-1:0] wrap_bytes;
   logic [AW-1:0] wrap_mask;
   logic [AW-1:0] incr_addr;

   // INCR aligns down to the beat size before stepping, so an unaligned
   // start address only affects the first beat. WRAP keeps the upper bits
   // of the wrap window and lets the low bits roll over inside it.
   always_comb begin
      beat_bytes = AW'(1) << size;
      size_mask  = beat_bytes - AW'(1);
      wrap_bytes = (AW'(len) + AW'(1)) << size;
      wrap_mask  = wrap_bytes - AW'(1);
      incr_addr  = addr + beat_bytes;
      next_addr  = addr;
      case (burst)
         INCR:    next_addr = (addr & ~size_mask) + beat_bytes;
         WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default: next_addr = addr;
      endcase
   end

endmodule

// File: rtl/axi_read_slave_resp.sv
// ---------------------------------------------------------------------------
// axi_read_slave_resp
// AXI4 read-channel responder in front of a 1-cycle-latency memory port.
// Accepts one AR request at a time, walks the burst addresses, fetches each
// beat from memory and returns it on R with RID/RRESP/RLAST under RREADY
// backpressure. Illegal requests are answered with SLVERR beats and never
// touch memory.
//   clk, resetn     : clock, asynchronous active-low reset
//   s_axi_ar*       : read address channel (slave side)
//   s_axi_r*        : read data channel (slave side)
//   mem_req/addr    : one-cycle read strobe and beat address
//   mem_rdata       : memory data, valid the cycle after mem_req
// ---------------------------------------------------------------------------
module axi_read_slave_resp
   import axi_pkg::*;
#(
   parameter int IDW = 12,
   parameter int AW  = 32,
   parameter int DW  = 64
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic [IDW-1:0] s_axi_arid,
   input  logic [AW-1:0]  s_axi_araddr,
   input  logic [7:0]     s_axi_arlen,
   input  logic [2:0]     s_axi_arsize,
   input  logic [1:0]     s_axi_arburst,
   input  logic           s_axi_arvalid,
   output logic           s_axi_arready,
   output logic [IDW-1:0] s_axi_rid,
   output logic [DW-1:0]  s_axi_rdata,
   output logic [1:0]     s_axi_rresp,
   output logic           s_axi_rlast,
   output logic           s_axi_rvalid,
   input  logic           s_axi_rready,
   output logic           mem_req,
   output logic [AW-1:0]  mem_addr,
   input  logic [DW-1:0]  mem_rdata
);

   localparam int MAX_SIZE = $clog2(DW / 8);

   state_e         state_q,   state_d;
   logic [IDW-1:0] id_q,      id_d;
   logic [AW-1:0]  addr_q,    addr_d;
   logic [7:0]     len_q,     len_d;
   logic [2:0]     size_q,    size_d;
   logic [1:0]     burst_q,   burst_d;
   logic           err_q,     err_d;
   logic [7:0]     count_q,   count_d;
   logic           arready_q, arready_d;
   logic           rvalid_q,  rvalid_d;
   logic           rlast_q,   rlast_d;
   logic [1:0]     rresp_q,   rresp_d;
   logic [DW-1:0]  rdata_q,   rdata_d;
   logic           mem_req_q, mem_req_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;

   logic [AW-1:0]  next_addr;
   logic           ar_hs;
   logic           r_hs;
   logic           ar_err;

   axi_burst_addr_gen #(
      .AW (AW)
   ) u_addr_gen (
      .addr      (addr_q),
      .len       (len_q),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   // Handshakes and request legality. A request is illegal when the beat is
   // wider than the data bus, the burst type is reserved, or a WRAP burst
   // has a length other than 2/4/8/16 beats.
   always_comb begin
      ar_hs  = s_axi_arvalid & arready_q;
      r_hs   = rvalid_q & s_axi_rready;
      ar_err = (int'(s_axi_arsize) > MAX_SIZE)
             | (s_axi_arburst == BURST_RSVD)
             | ((s_axi_arburst == WRAP) & ~wrap_len_ok(s_axi_arlen));
   end

   // Next-state and registered-output logic. Every output is a flop, so the
   // value for a state is prepared on the transition into it: mem_req is
   // raised when entering FETCH, rvalid when entering RESP. In an error
   // burst, rvalid dropping for one cycle inside RESP marks the gap before
   // the next SLVERR beat is presented.
   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      addr_d     = addr_q;
      len_d      = len_q;
      size_d     = size_q;
      burst_d    = burst_q;
      err_d      = err_q;
      count_d    = count_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rlast_d    = rlast_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      mem_req_d  = 1'b0;
      mem_addr_d = '0;

      case (state_q)
         IDLE: begin
            arready_d = 1'b1;
            if (ar_hs) begin
               arready_d = 1'b0;
               id_d      = s_axi_arid;
               addr_d    = s_axi_araddr;
               len_d     = s_axi_arlen;
               size_d    = s_axi_arsize;
               burst_d   = s_axi_arburst;
               err_d     = ar_err;
               count_d   = 8'd0;
               if (ar_err) begin
                  state_d  = RESP;
                  rvalid_d = 1'b1;
                  rdata_d  = '0;
                  rresp_d  = SLVERR;
                  rlast_d  = (s_axi_arlen == 8'd0);
               end else begin
                  state_d    = FETCH;
                  mem_req_d  = 1'b1;
                  mem_addr_d = s_axi_araddr;
               end
            end
         end

         FETCH: begin
            state_d = CAPTURE;
         end

         CAPTURE: begin
            rdata_d  = mem_rdata;
            rresp_d  = OKAY;
            rvalid_d = 1'b1;
            rlast_d  = (count_q == len_q);
            state_d  = RESP;
         end

         RESP: begin
            if (r_hs) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
               if (rlast_q) begin
                  state_d   = IDLE;
                  arready_d = 1'b1;
               end else begin
                  count_d = count_q + 8'd1;
                  addr_d  = next_addr;
                  if (!err_q) begin
                     state_d    = FETCH;
                     mem_req_d  = 1'b1;
                     mem_addr_d = next_addr;
                  end
               end
            end else if (!rvalid_q && err_q) begin
               rvalid_d = 1'b1;
               rdata_d  = '0;
               rresp_d  = SLVERR;
               rlast_d  = (count_q == len_q);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything asynchronously so
   // an in-flight burst is abandoned immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         err_q      <= 1'b0;
         count_q    <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rresp_q    <= '0;
         rdata_q    <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         size_q     <= size_d;
         burst_q    <= burst_d;
         err_q      <= err_d;
         count_q    <= count_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rlast_q    <= rlast_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rid     = id_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;
   assign s_axi_rvalid  = rvalid_q;
   assign mem_req       = mem_req_q;
   assign mem_addr      = mem_addr_q;

endmodule

// File: tb/tb_axi_read_slave_resp.sv
// ---------------------------------------------------------------------------
// tb_axi_read_slave_resp
// Self-checking bench for axi_read_slave_resp: a table of AR requests with
// hand-computed beat addresses, plus hand-written sequences for RREADY
// backpressure and reset in the middle of a burst. A small memory model
// returns data derived from the requested address.
// ---------------------------------------------------------------------------
module tb_axi_read_slave_resp;

   localparam int IDW = 12;
   localparam int AW  = 32;
   localparam int DW  = 64;

   typedef struct {
      logic [11:0]        id;
      logic [31:0]        addr;
      logic [7:0]         len;
      logic [2:0]         size;
      logic [1:0]         burst;
      logic               err;
      logic [0:7][31:0]   exp_addr;
   } vec_t;

   logic           clk;
   logic           resetn;
   logic [IDW-1:0] s_axi_arid;
   logic [AW-1:0]  s_axi_araddr;
   logic [7:0]     s_axi_arlen;
   logic [2:0]     s_axi_arsize;
   logic [1:0]     s_axi_arburst;
   logic           s_axi_arvalid;
   logic           s_axi_arready;
   logic [IDW-1:0] s_axi_rid;
   logic [DW-1:0]  s_axi_rdata;
   logic [1:0]     s_axi_rresp;
   logic           s_axi_rlast;
   logic           s_axi_rvalid;
   logic           s_axi_rready;
   logic           mem_req;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_rdata;

   int checks_total;
   int checks_passed;

   logic [31:0] mem_log[$];
   logic [63:0] beat_data[$];
   logic [1:0]  beat_resp[$];
   logic        beat_last[$];
   logic [11:0] beat_id[$];

   vec_t vecs[10];

   axi_read_slave_resp #(
      .IDW (IDW),
      .AW  (AW),
      .DW  (DW)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_axi_arid    (s_axi_arid),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arlen   (s_axi_arlen),
      .s_axi_arsize  (s_axi_arsize),
      .s_axi_arburst (s_axi_arburst),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rid     (s_axi_rid),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rlast   (s_axi_rlast),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] exp_data(input logic [31:0] a);
      return {a ^ 32'hA5A5_5A5A, a};
   endfunction

   // Memory with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_req) mem_rdata <= exp_data(mem_addr);
   end

   // Passive monitor: logs every memory strobe and every accepted R beat,
   // sampled on the falling edge away from the DUT's active edge.
   always @(negedge clk) begin
      if (resetn) begin
         if (mem_req) mem_log.push_back(mem_addr);
         if (s_axi_rvalid && s_axi_rready) begin
            beat_data.push_back(s_axi_rdata);
            beat_resp.push_back(s_axi_rresp);
            beat_last.push_back(s_axi_rlast);
            beat_id.push_back(s_axi_rid);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic clearLogs();
      mem_log.delete();
      beat_data.delete();
      beat_resp.delete();
      beat_last.delete();
      beat_id.delete();
   endtask

   // Presents an AR request (starting just after a rising edge) and returns
   // just after the edge on which it was accepted.
   task automatic applyStimulus(input vec_t v, input string tag);
      logic hs;
      logic ok;
      ok            = 1'b0;
      s_axi_arid    = v.id;
      s_axi_araddr  = v.addr;
      s_axi_arlen   = v.len;
      s_axi_arsize  = v.size;
      s_axi_arburst = v.burst;
      s_axi_arvalid = 1'b1;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         hs = s_axi_arready;
         @(posedge clk);
         #1;
         if (hs) ok = 1'b1;
      end
      s_axi_arvalid = 1'b0;
      checkOutput({tag, " ar_accept"}, 64'(ok), 64'd1);
   endtask

   task automatic runVector(input int idx);
      vec_t  v;
      int    n_beats;
      int    n_got;
      int    n_mem;
      string tag;
      v       = vecs[idx];
      n_beats = int'(v.len) + 1;
      tag     = $sformatf("v%0d", idx);
      clearLogs();
      applyStimulus(v, tag);

      if (v.err) begin
         @(negedge clk);
         checkOutput({tag, " err_first_rvalid"}, 64'(s_axi_rvalid), 64'd1);
         checkOutput({tag, " err_no_mem_req"}, 64'(mem_req), 64'd0);
      end else begin
         @(negedge clk);
         checkOutput({tag, " fetch_mem_req"}, 64'(mem_req), 64'd1);
         checkOutput({tag, " fetch_addr0"}, 64'(mem_addr), 64'(v.exp_addr[0]));
         @(negedge clk);
         checkOutput({tag, " capture_no_rvalid"}, 64'(s_axi_rvalid), 64'd0);
         @(negedge clk);
         checkOutput({tag, " first_rvalid"}, 64'(s_axi_rvalid), 64'd1);
      end

      for (int c = 0; c < 200 && beat_data.size() < n_beats; c++) @(negedge clk);
      checkOutput({tag, " beats_done"}, 64'(beat_data.size() >= n_beats), 64'd1);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, " arready_back"}, 64'(s_axi_arready), 64'd1);
      checkOutput({tag, " rvalid_low"}, 64'(s_axi_rvalid), 64'd0);
      repeat (3) @(negedge clk);

      checkOutput({tag, " beat_count"}, 64'(beat_data.size()), 64'(n_beats));
      checkOutput({tag, " mem_req_count"}, 64'(mem_log.size()),
                  v.err ? 64'd0 : 64'(n_beats));
      n_got = (beat_data.size() < n_beats) ? beat_data.size() : n_beats;
      for (int i = 0; i < n_got; i++) begin
         checkOutput($sformatf("%s b%0d rid", tag, i), 64'(beat_id[i]), 64'(v.id));
         checkOutput($sformatf("%s b%0d rresp", tag, i), 64'(beat_resp[i]),
                     v.err ? 64'd2 : 64'd0);
         checkOutput($sformatf("%s b%0d rlast", tag, i), 64'(beat_last[i]),
                     64'(i == n_beats - 1));
         checkOutput($sformatf("%s b%0d rdata", tag, i), beat_data[i],
                     v.err ? 64'd0 : exp_data(v.exp_addr[i]));
      end
      n_mem = v.err ? 0 : ((mem_log.size() < n_beats) ? mem_log.size() : n_beats);
      for (int i = 0; i < n_mem; i++) begin
         checkOutput($sformatf("%s mem_addr%0d", tag, i), 64'(mem_log[i]),
                     64'(v.exp_addr[i]));
      end
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for rvalid on a falling edge.
   task automatic waitRvalid(input string name);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = s_axi_rvalid;
      end
      checkOutput(name, 64'(seen), 64'd1);
   endtask

   initial begin
      vec_t  bp;
      vec_t  mr;
      logic  stable;
      logic  stray;
      logic [63:0] held_data;
      int    req_seen;

      checks_total  = 0;
      checks_passed = 0;
      resetn        = 1'b0;
      s_axi_arid    = '0;
      s_axi_araddr  = '0;
      s_axi_arlen   = '0;
      s_axi_arsize  = '0;
      s_axi_arburst = '0;
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b1;

      vecs[0] = '{12'h001, 32'h0000_1000, 8'd3, 3'd3, 2'b01, 1'b0,
                  {32'h1000, 32'h1008, 32'h1010, 32'h1018, 32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[1] = '{12'h002, 32'h0000_1038, 8'd7, 3'd3, 2'b10, 1'b0,
                  {32'h1038, 32'h1000, 32'h1008, 32'h1010, 32'h1018, 32'h1020, 32'h1028, 32'h1030}};
      vecs[2] = '{12'hABC, 32'h0000_0020, 8'd2, 3'd3, 2'b00, 1'b0,
                  {32'h20, 32'h20, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[3] = '{12'h005, 32'h0000_1003, 8'd2, 3'd2, 2'b01, 1'b0,
                  {32'h1003, 32'h1004, 32'h1008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[4] = '{12'h007, 32'h0000_4000, 8'd1, 3'd4, 2'b01, 1'b1,
                  {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[5] = '{12'h008, 32'h0000_5000, 8'd2, 3'd3, 2'b10, 1'b1,
                  {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[6] = '{12'h099, 32'h0000_6000, 8'd0, 3'd3, 2'b11, 1'b1,
                  {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[7] = '{12'h0F0, 32'h0000_0040, 8'd0, 3'd3, 2'b01, 1'b0,
                  {32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[8] = '{12'h123, 32'h0000_000C, 8'd3, 3'd2, 2'b10, 1'b0,
                  {32'h0C, 32'h00, 32'h04, 32'h08, 32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[9] = '{12'hFFF, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 1'b0,
                  {32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};

      #1;
      checkOutput("reset arready", 64'(s_axi_arready), 64'd0);
      checkOutput("reset rvalid", 64'(s_axi_rvalid), 64'd0);
      checkOutput("reset rlast", 64'(s_axi_rlast), 64'd0);
      checkOutput("reset rdata", s_axi_rdata, 64'd0);
      checkOutput("reset mem_req", 64'(mem_req), 64'd0);
      checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle arready", 64'(s_axi_arready), 64'd1);

      for (int v = 0; v < 10; v++) runVector(v);

      // Backpressure on the second (last) beat of a two-beat INCR burst.
      $display("[TB] backpressure sequence");
      clearLogs();
      bp = '{12'h033, 32'h0000_2000, 8'd1, 3'd3, 2'b01, 1'b0,
             {32'h2000, 32'h2008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
      s_axi_rready = 1'b1;
      applyStimulus(bp, "bp");
      waitRvalid("bp beat1_rvalid");
      @(posedge clk);
      #1;
      s_axi_rready = 1'b0;
      waitRvalid("bp beat2_rvalid");
      held_data = s_axi_rdata;
      checkOutput("bp beat2_rdata", held_data, exp_data(32'h2008));
      checkOutput("bp beat2_rlast", 64'(s_axi_rlast), 64'd1);
      stable   = 1'b1;
      req_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (!s_axi_rvalid || !s_axi_rlast || s_axi_rdata !== held_data) stable = 1'b0;
         if (mem_req) req_seen++;
      end
      checkOutput("bp held_stable", 64'(stable), 64'd1);
      checkOutput("bp no_mem_req_stall", 64'(req_seen), 64'd0);
      @(posedge clk);
      #1;
      s_axi_rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp arready_back", 64'(s_axi_arready), 64'd1);
      checkOutput("bp rvalid_low", 64'(s_axi_rvalid), 64'd0);
      checkOutput("bp mem_req_total", 64'(mem_log.size()), 64'd2);
      checkOutput("bp beat_total", 64'(beat_data.size()), 64'd2);
      @(posedge clk);
      #1;

      // Reset asserted while beat 2 of an 8-beat burst is being presented.
      $display("[TB] mid-burst reset sequence");
      clearLogs();
      mr = '{12'h044, 32'h0000_3000, 8'd7, 3'd3, 2'b01, 1'b0,
             {32'h3000, 32'h3008, 32'h3010, 32'h3018, 32'h3020, 32'h3028, 32'h3030, 32'h3038}};
      applyStimulus(mr, "mr");
      waitRvalid("mr beat1_rvalid");
      @(posedge clk);
      #1;
      waitRvalid("mr beat2_rvalid");
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("mr async arready", 64'(s_axi_arready), 64'd0);
      checkOutput("mr async rvalid", 64'(s_axi_rvalid), 64'd0);
      checkOutput("mr async rlast", 64'(s_axi_rlast), 64'd0);
      checkOutput("mr async rresp", 64'(s_axi_rresp), 64'd0);
      checkOutput("mr async rid", 64'(s_axi_rid), 64'd0);
      checkOutput("mr async rdata", s_axi_rdata, 64'd0);
      checkOutput("mr async mem_req", 64'(mem_req), 64'd0);
      checkOutput("mr async mem_addr", 64'(mem_addr), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      clearLogs();
      stray = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (s_axi_rvalid || mem_req) stray = 1'b1;
      end
      checkOutput("mr no_stale_activity", 64'(stray), 64'd0);
      checkOutput("mr arready_after", 64'(s_axi_arready), 64'd1);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
